// File: rtl/divider.sv
// Unsigned restoring divider: one quotient bit per RUN cycle, MSB first.
// Optional macro DIVIDER_ZERO_FAST_EN finishes a divide-by-zero one edge after capture.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_division,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remOut_q, remOut_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             qBit;
  logic [WIDTH:0]   remNext;
  logic [WIDTH-1:0] dvdNext;
  logic             zeroFast;

  // One restoring step; the extra top bit of diff is the borrow that rejects the subtraction.
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    diff    = shifted - {2'b00, dvs_q};
    qBit    = ~diff[WIDTH+1];
    remNext = qBit ? diff[WIDTH:0] : shifted[WIDTH:0];
    dvdNext = {dvd_q[WIDTH-2:0], qBit};
  end

`ifdef DIVIDER_ZERO_FAST_EN
  assign zeroFast = (dvs_q == '0);
`else
  assign zeroFast = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    quot_d   = quot_q;
    remOut_d = remOut_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_division) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          count_d = CW'(WIDTH);
          state_d = RUN;
        end
      end
      RUN: begin
        if (zeroFast) begin
          quot_d   = '1;
          remOut_d = dvd_q;
          count_d  = '0;
          state_d  = DONE;
        end else begin
          rem_d   = remNext;
          dvd_d   = dvdNext;
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            quot_d   = dvdNext;
            remOut_d = remNext[WIDTH-1:0];
            state_d  = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      quot_q   <= '0;
      remOut_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      quot_q   <= quot_d;
      remOut_q <= remOut_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = remOut_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (WIDTH >= 2).
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start_division  input  1  request to begin a division; sampled on a rising edge.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned dividend; sampled with start_division.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned divisor; sampled with start_division.
REQ-007 SHALL have port quotient  output  WIDTH  registered quotient of the last completed division.
REQ-008 SHALL have port remainder  output  WIDTH  registered remainder of the last completed division.
REQ-009 SHALL have port busy  output  1  high while an iteration sequence is running.
REQ-010 SHALL have port done  output  1  high while quotient/remainder hold a fresh result.
REQ-011 SHALL use one clock and a synchronous, active-high reset; no other clock or asynchronous path.

Function
REQ-012 SHALL implement an unsigned restoring divider, one quotient bit per RUN cycle, MSB first.
REQ-013 SHALL use FSM states IDLE, RUN and DONE; busy=1 exactly in RUN, done=1 exactly in DONE.
REQ-014 IDLE or DONE with start_division=1 at an edge: capture dividend/divisor, clear the partial remainder, load the iteration counter with WIDTH, go to RUN.
REQ-015 Each RUN edge: shift {partial remainder, dividend} left one bit; subtract divisor from the partial remainder if the result is non-negative and set the quotient bit; decrement the counter.
REQ-016 On the RUN edge where the counter reaches 0: write quotient/remainder, go to DONE; latency = WIDTH edges after the capture edge.
REQ-017 quotient/remainder SHALL change only on DONE entry; they hold the previous result during RUN.
REQ-018 SHALL ignore start_division in RUN; operands in flight are not disturbed.
REQ-019 SHALL stay in DONE, outputs stable, until start_division (REQ-014) or reset; start in DONE drops done on the capture edge.
REQ-020 Partial remainder SHALL be WIDTH+1 bits internally so no subtraction overflows for any operands.
REQ-021 Divisor 0 SHALL give quotient all ones and remainder = dividend, matching RISC-V DIVU/REMU.
REQ-022 Dividend < divisor SHALL give quotient 0 and remainder = dividend after the full latency.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE and busy=0, done=0, quotient=0, remainder=0, counter=0.
REQ-024 reset SHALL have priority over start_division and abort a RUN in progress; no partial result appears.
REQ-025 After reset releases, start_division on the first edge with reset=0 SHALL be accepted.

Configuration
REQ-026 Macro DIVIDER_ZERO_FAST_EN SHALL, when defined, make divisor==0 at capture go directly to DONE on the next edge with REQ-021 results (latency 1).
REQ-027 Without DIVIDER_ZERO_FAST_EN, divisor 0 SHALL run all WIDTH iterations and yield REQ-021 results through the normal datapath; results are identical in both builds, only latency differs.

Verification
REQ-028 Check: 0x0000827D / 0x00000083 -> quotient 0x000000FF, remainder 0x00000000, done high exactly 32 edges after capture.
REQ-029 Check: 0x00007C33 / 0x000000AA -> quotient 0x000000BB, remainder 0x00000005; then 0xFFFFFFFF / 0x00000001 -> quotient 0xFFFFFFFF, remainder 0.
REQ-030 Check: 0x00001234 / 0 -> quotient 0xFFFFFFFF, remainder 0x00001234; done after 1 edge with DIVIDER_ZERO_FAST_EN defined, after 32 edges without it.
REQ-031 Check: start 0x64/0x7, then start_division with 0x10/0x2 at RUN cycle 5 -> the second request is ignored; result quotient 0x0E, remainder 0x02.
REQ-032 Check: reset asserted at RUN cycle 10 -> next edge busy=0, done=0, quotient=0, remainder=0; a new start then completes normally.
REQ-033 Check: start_division held high in DONE -> a new capture occurs, done drops, and the result updates 32 edges later.
